// File: rtl/rx_ber_checker.sv
`default_nettype none
// ============================================================================
//  Module   : rx_ber_checker
//  Purpose  : Receive-side BER checker. Decimates 8x oversampled SRRC
//             samples at a selectable phase, hard-slices each symbol and
//             compares it with a delayed copy of the transmit PRBS stream.
//             A full delay sweep picks the delay with the fewest errors
//             per window, then the checker locks and accumulates bit and
//             error counts until the error rate forces a new sweep.
//  Revision : 1.0 - initial release
// ============================================================================
module rx_ber_checker #(
    parameter int NB_IN    = 8,
    parameter int NB_PHASE = 3,
    parameter int NB_DELAY = 9,
    parameter int WINDOW   = 1024,
    parameter int NB_WIN   = 11,
    parameter int LOSS_THR = 64,
    parameter int NB_CNT   = 64
) (
    input  logic                clock,
    input  logic                in_reset,
    input  logic                in_enable,
    input  logic [NB_IN-1:0]    in_sample,
    input  logic                in_valid_sample,
    input  logic [NB_PHASE-1:0] in_phase,
    input  logic                in_ref_bit,
    input  logic                in_ref_valid,
    output logic                out_rx_bit,
    output logic                out_rx_bit_valid,
    output logic                out_lock,
    output logic [NB_DELAY-1:0] out_delay,
    output logic [NB_CNT-1:0]   out_bit_count,
    output logic [NB_CNT-1:0]   out_err_count
);

    localparam int                DEPTH      = 2 ** NB_DELAY;
    localparam logic [NB_WIN-1:0] WIN_LAST   = NB_WIN'(WINDOW - 1);
    localparam logic [NB_WIN-1:0] LOSS_LIM   = NB_WIN'(LOSS_THR);
    localparam logic [NB_DELAY-1:0] DELAY_LAST = '1;
    localparam logic [NB_CNT-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCK   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q;
    logic [NB_PHASE-1:0] phase_q;
    logic [DEPTH-1:0]    ref_buf_q;
    logic [NB_DELAY-1:0] delay_q;
    logic [NB_DELAY-1:0] best_delay_q;
    logic [NB_WIN-1:0]   min_err_q;
    logic [NB_WIN-1:0]   win_cnt_q;
    logic [NB_WIN-1:0]   win_err_q;
    logic [NB_CNT-1:0]   bit_cnt_q;
    logic [NB_CNT-1:0]   err_cnt_q;
    logic                rx_bit_q;
    logic                rx_valid_q;
    logic                lock_q;

    // ------------------------------------------------------------------
    // Next-state / decode helpers
    // ------------------------------------------------------------------
    logic                strobe_d;
    logic                rx_bit_d;
    logic                err_d;
    logic                win_end_d;
    logic                better_d;
    logic [NB_WIN-1:0]   win_err_d;
    logic [NB_DELAY-1:0] best_delay_d;
    logic [NB_CNT-1:0]   bit_cnt_d;
    logic [NB_CNT-1:0]   err_cnt_d;

    // Only the sign bit of a sample carries the hard decision.
    logic unused_sample_bits;
    assign unused_sample_bits = ^in_sample[NB_IN-2:0];

    // Symbol strobe, slicer, error bit and window / accumulator arithmetic.
    // The compare bit is read from the buffer before any shift this cycle.
    always_comb begin
        strobe_d     = in_valid_sample && (phase_q == in_phase);
        rx_bit_d     = in_sample[NB_IN-1];
        err_d        = strobe_d && (rx_bit_d ^ ref_buf_q[delay_q]);
        win_err_d    = win_err_q + {{(NB_WIN-1){1'b0}}, err_d};
        win_end_d    = (win_cnt_q == WIN_LAST);
        better_d     = (win_err_d < min_err_q);
        best_delay_d = better_d ? delay_q : best_delay_q;
        bit_cnt_d    = (bit_cnt_q == CNT_MAX) ? bit_cnt_q : bit_cnt_q + NB_CNT'(1);
        err_cnt_d    = (err_d && (err_cnt_q != CNT_MAX)) ? err_cnt_q + NB_CNT'(1)
                                                         : err_cnt_q;
    end

    // Sample phase counter: advances on every sample, wraps naturally.
    always_ff @(posedge clock) begin
        if (in_reset) begin
            phase_q <= '0;
        end else if (in_valid_sample) begin
            phase_q <= phase_q + NB_PHASE'(1);
        end
    end

    // Reference history: newest bit enters at index 0.
    always_ff @(posedge clock) begin
        if (in_reset) begin
            ref_buf_q <= '0;
        end else if (in_ref_valid) begin
            ref_buf_q <= {ref_buf_q[DEPTH-2:0], in_ref_bit};
        end
    end

    // Sliced bit register and its one-cycle valid pulse.
    always_ff @(posedge clock) begin
        if (in_reset) begin
            rx_bit_q   <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= strobe_d;
            if (strobe_d) begin
                rx_bit_q <= rx_bit_d;
            end
        end
    end

    // Search / lock controller with windowed error counting and accumulators.
    always_ff @(posedge clock) begin
        if (in_reset) begin
            state_q      <= ST_IDLE;
            lock_q       <= 1'b0;
            delay_q      <= '0;
            best_delay_q <= '0;
            min_err_q    <= '1;
            win_cnt_q    <= '0;
            win_err_q    <= '0;
            bit_cnt_q    <= '0;
            err_cnt_q    <= '0;
        end else if (!in_enable) begin
            // Disabling abandons any sweep or lock; counters simply hold.
            state_q <= ST_IDLE;
            lock_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q   <= ST_SEARCH;
                    lock_q    <= 1'b0;
                    delay_q   <= '0;
                    win_cnt_q <= '0;
                    win_err_q <= '0;
                    min_err_q <= '1;
                end

                ST_SEARCH: begin
                    if (strobe_d) begin
                        if (win_end_d) begin
                            win_cnt_q    <= '0;
                            win_err_q    <= '0;
                            best_delay_q <= best_delay_d;
                            if (better_d) begin
                                min_err_q <= win_err_d;
                            end
                            if (delay_q == DELAY_LAST) begin
                                // Sweep complete: settle on the best delay seen.
                                state_q   <= ST_LOCK;
                                lock_q    <= 1'b1;
                                delay_q   <= best_delay_d;
                                bit_cnt_q <= '0;
                                err_cnt_q <= '0;
                            end else begin
                                delay_q <= delay_q + NB_DELAY'(1);
                            end
                        end else begin
                            win_cnt_q <= win_cnt_q + NB_WIN'(1);
                            win_err_q <= win_err_d;
                        end
                    end
                end

                ST_LOCK: begin
                    if (strobe_d) begin
                        bit_cnt_q <= bit_cnt_d;
                        err_cnt_q <= err_cnt_d;
                        if (win_err_d >= LOSS_LIM) begin
                            // Too many errors in this window: restart the
                            // sweep. Checked before window end so loss wins.
                            state_q   <= ST_SEARCH;
                            lock_q    <= 1'b0;
                            delay_q   <= '0;
                            min_err_q <= '1;
                            win_cnt_q <= '0;
                            win_err_q <= '0;
                        end else if (win_end_d) begin
                            win_cnt_q <= '0;
                            win_err_q <= '0;
                        end else begin
                            win_cnt_q <= win_cnt_q + NB_WIN'(1);
                            win_err_q <= win_err_d;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    lock_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_rx_bit       = rx_bit_q;
    assign out_rx_bit_valid = rx_valid_q;
    assign out_lock         = lock_q;
    assign out_delay        = delay_q;
    assign out_bit_count    = bit_cnt_q;
    assign out_err_count    = err_cnt_q;

endmodule
`default_nettype wire

// File: doc/rx_ber_checker.md
# rx_ber_checker

Receive-side BER checker. It consumes the SRRC transmit filter output samples (8 samples per symbol) and decimates them to one sample per symbol at a selectable phase. Each decimated sample is hard-sliced to a bit and compared against the transmit PRBS reference bit stream. The block finds the loopback delay by an error-count sweep, then locks and accumulates bit and error counts for readback through VIO/ILA.

## Interface
Parameters:
- NB_IN, 8, width of signed input sample (matches SRRC output width).
- NB_PHASE, 3, phase counter width; oversampling factor is 2^NB_PHASE = 8.
- NB_DELAY, 9, delay-select width; reference buffer depth is 2^NB_DELAY = 512 bits.
- WINDOW, 1024, symbols per error-count window (must exceed PRBS9 period 511).
- NB_WIN, 11, window counter width (holds WINDOW).
- LOSS_THR, 64, errors per window in LOCK that force loss of lock.
- NB_CNT, 64, width of bit and error accumulators.

Ports:
- clock, in, 1, system clock.
- in_reset, in, 1, synchronous active-high reset.
- in_enable, in, 1, checker enable; 0 forces IDLE.
- in_sample, in, NB_IN, signed SRRC output sample.
- in_valid_sample, in, 1, sample strobe (8 MHz ctrl valid).
- in_phase, in, NB_PHASE, sample phase used as symbol decision point.
- in_ref_bit, in, 1, transmitted PRBS bit.
- in_ref_valid, in, 1, reference strobe (1/T ctrl valid AND PRBS enable).
- out_rx_bit, out, 1, last sliced bit.
- out_rx_bit_valid, out, 1, one-cycle pulse per sliced bit.
- out_lock, out, 1, 1 while in LOCK.
- out_delay, out, NB_DELAY, current or locked delay.
- out_bit_count, out, NB_CNT, symbols compared since lock.
- out_err_count, out, NB_CNT, errors since lock.

## Operation
- Phase counter: 0 after reset, +1 on each in_valid_sample, wraps 7->0. A symbol strobe occurs when in_valid_sample=1 and phase counter == in_phase (pre-increment value).
- Slicer: rx_bit = in_sample[NB_IN-1]. A negative sample gives bit 1, matching TX mapping 1 -> negative.
- Reference buffer: 512-bit shift register, shifts in in_ref_bit on in_ref_valid; index 0 is newest. Compare bit is ref_buf[delay].
- Error on a symbol strobe = rx_bit XOR compare bit.
- FSM states:
  - IDLE: entered on reset or in_enable=0. Outputs out_lock=0; counters hold. The in_enable 0->1 transition moves to SEARCH with delay=0, window count 0, min_err = all ones.
  - SEARCH: errors are counted for WINDOW symbols at the current delay. At window end, if errors < min_err (strict), record min_err and best_delay. Then delay+1.
    - Sweep ends after delay 511 finishes. On sweep end, go to LOCK with delay=best_delay, and clear out_bit_count and out_err_count.
  - LOCK: out_lock=1. Each strobe adds +1 to out_bit_count and +error to out_err_count.
    - Per-window error counter: if it reaches LOSS_THR within one window, go to SEARCH (restart sweep at delay 0, min_err reset, out_lock=0). Accumulators keep their values.
- Accumulators saturate at all ones; they never wrap.
- out_delay shows the sweep delay in SEARCH and the locked delay in LOCK.

## Timing
- Reset values: all outputs 0, state IDLE, phase counter 0, reference buffer 0, delay 0.
- out_rx_bit and out_rx_bit_valid are registered 1 cycle after the symbol strobe.
- Counter and FSM updates from a strobe are visible 1 cycle after the strobe.
- out_lock rises 1 cycle after the last strobe of the sweep.
- Simultaneous in_ref_valid and symbol strobe: the comparison uses the buffer contents before this cycle's shift.
- in_phase changes take effect on the next sample; no resync is done.
- in_enable=0 mid-SEARCH or mid-LOCK: IDLE on the next cycle; the window and sweep are discarded.
- in_reset mid-operation: everything returns to reset values the next cycle, including the accumulators.
- A window that ends on the same strobe as LOSS_THR being reached is treated as loss of lock (loss takes priority).

## Test plan
- Reset: assert in_reset 3 cycles during traffic -> all outputs 0, state IDLE. With in_enable=0 and traffic applied -> out_lock stays 0 indefinitely.
- Clean loopback: PRBS9 ref, sample held at +/-64 for 8 samples per bit, RX delayed 37 symbols, in_phase=0 -> after 512*1024 symbols out_lock=1, out_delay=37. After a further 10000 symbols, out_bit_count=10000 and out_err_count=0.
- Single error: in lock, invert one symbol's 8 samples -> out_err_count=1 and out_lock stays 1.
- Loss of lock: in lock, invert 64 consecutive symbols -> out_lock=0 one cycle after the 64th strobe. The sweep restarts at delay 0 and relocks at delay 37; the accumulators are cleared on relock.
- Phase select: drive the valid symbol value only at sample phase 3, with inverted values at other phases. in_phase=3 -> lock with 0 errors. in_phase=2 -> after a sweep, LOCK on best_delay with error rate ~50%, then loss of lock within one window.
- Boundaries: with loopback delay 511 -> locks at out_delay=511. Force an accumulator to near-max via a long run (or reduced NB_CNT=8) -> the count saturates at 255 and holds.
